// File: rtl/reg_to_mem_store_unit_pkg.sv
// store_pkg: store-width encodings, FSM states and lane masks for reg_to_mem_store_unit.
package store_pkg;
  typedef enum logic [1:0] {ST_SW = 2'b00, ST_SH = 2'b01, ST_SB = 2'b10, ST_RSV = 2'b11} store_type_e;
  typedef enum logic [2:0] {IDLE, CHECK, READ, MERGE, WRITE, DONE} state_e;
  localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
  localparam logic [31:0] HALF_MASK = 32'h0000_ffff;
endpackage

// File: rtl/reg_to_mem_store_unit_if.sv
// reg_to_mem_store_unit_if: control/register side and memory port of the store unit.
interface reg_to_mem_store_unit_if;
  logic        start;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] reg_data;
  logic [31:0] mem_data_in;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_data_out;
  logic        busy;
  logic        done;
  logic        error;
  modport master (output start, store_type, addr, reg_data, mem_data_in,
                  input mem_addr, mem_wr, mem_data_out, busy, done, error);
  modport slave (input start, store_type, addr, reg_data, mem_data_in,
                 output mem_addr, mem_wr, mem_data_out, busy, done, error);
endinterface

// File: rtl/reg_to_mem_store_unit_lane_merge.sv
// store_lane_merge: drops the byte/half of data into the addressed little-endian lane of old_word.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  store_type_e st,
  input  logic [1:0]  off,
  output logic [31:0] merged
);
  logic [31:0] mask;
  logic [31:0] ins;
  always_comb begin
    mask = (st == ST_SB) ? BYTE_MASK << {off, 3'b000} : HALF_MASK << {off[1], 4'b0000};
    ins = (st == ST_SB) ? {4{data[7:0]}} : {2{data[15:0]}};
    merged = (st == ST_SW) ? data : (old_word & ~mask) | (ins & mask);
  end
endmodule

// File: rtl/reg_to_mem_store_unit.sv
// reg_to_mem_store_unit: SW direct write, SH/SB read-modify-write into word memory.
// Define STORE_MISALIGN_EXC_EN to reject misaligned SW/SH with error instead of aligning them.
module reg_to_mem_store_unit
  import store_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic reset,
  reg_to_mem_store_unit_if.slave bus
);
  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);
  state_e      state_q, state_d;
  store_type_e type_q, type_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, wdata_q, wdata_d, merged;
  logic        err_q, err_d, misalign;
  store_lane_merge u_merge (
    .old_word(bus.mem_data_in),
    .data(data_q),
    .st(type_q),
    .off(addr_q[1:0]),
    .merged(merged)
  );
`ifdef STORE_MISALIGN_EXC_EN
  assign misalign = (type_q == ST_SW && addr_q[1:0] != 2'b00) || (type_q == ST_SH && addr_q[0]);
`else
  assign misalign = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    type_d = type_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    wdata_d = wdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = CHECK;
        addr_d = bus.addr;
        data_d = bus.reg_data;
        type_d = store_type_e'(bus.store_type);
        err_d = 1'b0;
      end
      CHECK: begin
        err_d = type_q == ST_RSV || misalign;
        state_d = err_d ? DONE : (type_q == ST_SW ? WRITE : READ);
        cnt_d = LAT_M1;
        wdata_d = data_q;
      end
      READ: begin
        cnt_d = cnt_q - 2'd1;
        state_d = (cnt_q == 2'd0) ? MERGE : READ;
      end
      MERGE: begin
        wdata_d = merged;
        state_d = WRITE;
      end
      WRITE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      type_q <= ST_SW;
      cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q <= type_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wdata_q <= wdata_d;
      err_q <= err_d;
    end
  end
  assign bus.mem_addr = {addr_q[31:2], 2'b00};
  assign bus.mem_wr = state_q == WRITE;
  assign bus.mem_data_out = bus.mem_wr ? wdata_q : '0;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.error = bus.done && err_q;
endmodule
